// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with posted write buffer and wait-state drain
//
// Purpose: serves MEM-stage reads with one-cycle latency and posts writes into a
// small FIFO that a wait-state FSM drains into a word array. Reads own the array
// port; a pending commit is held off while rden is high. Reads forward from the
// youngest matching buffered write.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   rden       read request, rdaddr = byte address
//   wme        write request, maddr = byte address, wdata = data
//   rdata      read data, valid while rvalid=1
//   rvalid     one-cycle pulse one cycle after an accepted rden
//   wbuf_full  buffer holds WBUF_DEPTH entries
//   wbuf_empty no posted writes outstanding
//   addr_err   one-cycle pulse: illegal access seen last cycle
//   ovf_err    sticky: a legal write was dropped on a full buffer

module dmem_responder #(
  parameter int ADDR_W     = 10,
  parameter int WBUF_DEPTH = 4,
  parameter int WR_WAIT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rden,
  input  logic [31:0] rdaddr,
  input  logic        wme,
  input  logic [31:0] maddr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        wbuf_full,
  output logic        wbuf_empty,
  output logic        addr_err,
  output logic        ovf_err
);

  localparam int PW     = $clog2(WBUF_DEPTH);
  localparam int CW     = PW + 1;
  localparam int NWORDS = 1 << ADDR_W;
  localparam logic [CW-1:0] FULL_CNT  = CW'(WBUF_DEPTH);
  localparam logic [3:0]    WAIT_LOAD = 4'(WR_WAIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  // Storage: the array and the buffer payload are not reset.
  logic [31:0]       mem     [NWORDS];
  logic [ADDR_W-1:0] wb_idx  [WBUF_DEPTH];
  logic [31:0]       wb_data [WBUF_DEPTH];

  logic [CW-1:0] count_q;
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;

  state_t        state_q;
  state_t        state_d;
  logic [3:0]    cnt_q;
  logic [3:0]    cnt_d;

  logic [31:0]   rdata_q;
  logic          rvalid_q;
  logic          addr_err_q;
  logic          ovf_q;

  logic              rd_legal;
  logic              wr_legal;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] wr_idx;
  logic              fwd_hit;
  logic [31:0]       fwd_data;
  logic [PW-1:0]     slot;
  logic [31:0]       rd_value;
  logic              pop;
  logic              push;
  logic              drop;

  // Word-aligned and inside the array's address window.
  assign rd_legal = (rdaddr[1:0] == 2'b00) && ((rdaddr >> (ADDR_W + 2)) == 32'd0);
  assign wr_legal = (maddr[1:0] == 2'b00) && ((maddr >> (ADDR_W + 2)) == 32'd0);
  assign rd_idx   = rdaddr[ADDR_W+1:2];
  assign wr_idx   = maddr[ADDR_W+1:2];

  // Walk live entries oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 32'd0;
    slot     = head_q;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      slot = head_q + PW'(i);
      if ((CW'(i) < count_q) && (wb_idx[slot] == rd_idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[slot];
      end
    end
  end

  always_comb begin
    if (!rd_legal)    rd_value = 32'd0;
    else if (fwd_hit) rd_value = fwd_data;
    else              rd_value = mem[rd_idx];
  end

  // ---------------- drain FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- drain FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          if (WR_WAIT == 0) begin
            state_d = S_COMMIT;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        // A read owns the array port; the head is held until rden drops.
        if (!rden) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- drain FSM: outputs ----------------
  always_comb begin
    pop = 1'b0;
    unique case (state_q)
      S_COMMIT: pop = !rden;
      default:  pop = 1'b0;
    endcase
  end

  // A full buffer still accepts when the head leaves this same cycle.
  assign push = wme && wr_legal && ((count_q != FULL_CNT) || pop);
  assign drop = wme && wr_legal && !push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      rdata_q    <= 32'd0;
      rvalid_q   <= 1'b0;
      addr_err_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      if (rden) rdata_q <= rd_value;
      rvalid_q   <= rden;
      addr_err_q <= (rden && !rd_legal) || (wme && !wr_legal);
      if (drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wb_idx[tail_q]  <= wr_idx;
      wb_data[tail_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) mem[wb_idx[head_q]] <= wb_data[head_q];
  end

  assign rdata      = rdata_q;
  assign rvalid     = rvalid_q;
  assign wbuf_full  = (count_q == FULL_CNT);
  assign wbuf_empty = (count_q == '0);
  assign addr_err   = addr_err_q;
  assign ovf_err    = ovf_q;

endmodule
